// File: rtl/inst_bus_pkg.sv
// inst_bus_pkg: state encoding, default widths and master ids for the instruction-bus arbiter
package inst_bus_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ = 2'b01;
  localparam logic [1:0] RELEASE = 2'b11;
  localparam logic [1:0] DONE = 2'b10;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/inst_bus_arbiter_if.sv
// inst_bus_arbiter_if: master request/done signals plus the instruction-memory read port
interface inst_bus_arbiter_if
  import inst_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic m0_done;
  logic m1_done;
  logic [DATA_W-1:0] rdata;
  logic err;
  logic busy;
  logic mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input m0_req, m0_addr, m1_req, m1_addr, mem_ready, mem_rdata,
    output m0_done, m1_done, rdata, err, busy, mem_read, mem_address
  );
  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, mem_ready, mem_rdata,
    input m0_done, m1_done, rdata, err, busy, mem_read, mem_address
  );
endinterface

// File: rtl/ready_sync.sv
// ready_sync: flop chain bringing the off-clock memory ready into the clk domain
module ready_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  localparam int N = STAGES < 1 ? 1 : STAGES;
  logic [N-1:0] r_sync;
  // shift the input one stage per clock, cleared by the async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < N; i++) r_sync[i] <= r_sync[i-1];
    end
  end
  assign o_q = r_sync[N-1];
endmodule

// File: rtl/inst_bus_arbiter.sv
// inst_bus_arbiter: round-robin two-master arbiter driving a four-phase instruction-memory read
module inst_bus_arbiter
  import inst_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  inst_bus_arbiter_if.slave bus
);
  localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [1:0] r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_gnt, r_last, r_read, r_err, r_busy, r_done0, r_done1;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic w_rdy_s, w_win, w_cnt_max;
  ready_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .i_d(bus.mem_ready),
    .o_q(w_rdy_s)
  );
  assign w_cnt_max = r_cnt == CNT_MAX;
  // on a tie the master that was not served last wins
  assign w_win = (bus.m0_req && bus.m1_req) ? ~r_last : (bus.m1_req ? M1 : M0);
  // handshake FSM; the counter only advances below its limit, so it saturates instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_gnt <= M0;
      r_last <= M1;
      r_read <= 1'b0;
      r_addr <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: if (bus.m0_req || bus.m1_req) begin
          r_addr <= w_win ? bus.m1_addr : bus.m0_addr;
          r_read <= 1'b1;
          r_gnt <= w_win;
          r_last <= w_win;
          r_cnt <= '0;
          r_busy <= 1'b1;
          r_state <= REQ;
        end
        REQ: if (w_rdy_s) begin
          r_rdata <= bus.mem_rdata;
          r_err <= 1'b0;
          r_read <= 1'b0;
          r_cnt <= '0;
          r_state <= RELEASE;
        end else if (w_cnt_max) begin
          r_err <= 1'b1;
          r_read <= 1'b0;
          r_cnt <= '0;
          r_state <= RELEASE;
        end else r_cnt <= r_cnt + 1'b1;
        RELEASE: if (!w_rdy_s || w_cnt_max) begin
          r_err <= w_rdy_s | r_err;
          r_done0 <= r_gnt == M0;
          r_done1 <= r_gnt == M1;
          r_state <= DONE;
        end else r_cnt <= r_cnt + 1'b1;
        DONE: begin
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.mem_read = r_read;
  assign bus.mem_address = r_addr;
  assign bus.rdata = r_rdata;
  assign bus.err = r_err;
  assign bus.busy = r_busy;
  assign bus.m0_done = r_done0;
  assign bus.m1_done = r_done1;
endmodule

// File: tb/tb_inst_bus_arbiter.sv
// tb_inst_bus_arbiter: vector table, corner-case sequences and random traffic against a transaction model
module tb_inst_bus_arbiter;
  localparam int T = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  inst_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  inst_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int mode = 0;
  typedef struct {
    logic r0;
    logic r1;
    logic [31:0] a0;
    logic [31:0] a1;
    int exp_id;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[6];
  int id, rc, rl, extra, w;
  logic [31:0] rd;
  logic e;
  logic mfree, rel, mlast, exp_rise;
  logic [31:0] exp_addr;
  int q_id[$];
  logic [31:0] q_rd[$];
  // pseudo memory: ready (data = addr+4) 3 cycles after read rises, drops 2 cycles after read falls, off the clock edge
  initial begin
    int rd_cnt, fall_cnt;
    rd_cnt = 0;
    fall_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!reset) begin
        bus.mem_ready = 1'b0;
        rd_cnt = 0;
        fall_cnt = 0;
      end else if (bus.mem_read) begin
        fall_cnt = 0;
        rd_cnt++;
        if (rd_cnt == 3 && mode != 1) begin
          bus.mem_rdata = bus.mem_address + 32'd4;
          bus.mem_ready = 1'b1;
        end
      end else begin
        rd_cnt = 0;
        if (bus.mem_ready && mode != 2) begin
          fall_cnt++;
          if (fall_cnt == 2) begin
            bus.mem_ready = 1'b0;
            fall_cnt = 0;
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done(input int budget, output int oid, output logic [31:0] ord, output logic oe,
                           output int orc, output int orl);
    oid = -1;
    ord = '0;
    oe = 1'b0;
    orc = 0;
    orl = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done) begin
        oid = (bus.m0_done && bus.m1_done) ? 2 : (bus.m1_done ? 1 : 0);
        ord = bus.rdata;
        oe = bus.err;
        return;
      end
      if (bus.mem_read) orc++;
      else if (bus.busy) orl++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    #400000;
    $display("FAIL global time limit: got running expected finished");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h1000, 32'h0, 0, 32'h1004};
    vecs[1] = '{1'b1, 1'b1, 32'h2000, 32'h3000, 1, 32'h3004};
    vecs[2] = '{1'b1, 1'b1, 32'h2010, 32'h3010, 0, 32'h2014};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h40, 1, 32'h44};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h80, 1, 32'h84};
    vecs[5] = '{1'b1, 1'b1, 32'h500, 32'h600, 0, 32'h504};
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    bus.m0_addr = '0;
    bus.m1_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst mem_read", 32'(bus.mem_read), 0);
    chk("rst mem_address", bus.mem_address, 0);
    chk("rst rdata", bus.rdata, 0);
    chk("rst done", 32'({bus.m0_done, bus.m1_done}), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst busy", 32'(bus.busy), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // single read
    bus.m0_addr = 32'h100;
    bus.m0_req = 1'b1;
    @(negedge clk);
    chk("t1 read rise", 32'(bus.mem_read), 1);
    chk("t1 address", bus.mem_address, 32'h100);
    chk("t1 busy", 32'(bus.busy), 1);
    wait_done(40, id, rd, e, rc, rl);
    bus.m0_req = 1'b0;
    chk("t1 id", id, 0);
    chk("t1 rdata", rd, 32'h104);
    chk("t1 err", 32'(e), 0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done || bus.mem_read) extra++;
    end
    chk("t1 quiet after done", extra, 0);
    // contention from reset
    reset = 1'b0;
    bus.m0_addr = 32'h200;
    bus.m1_addr = 32'h300;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, id, rd, e, rc, rl);
      chk($sformatf("t2 id%0d", k), id, k % 2);
      chk($sformatf("t2 rdata%0d", k), rd, (k % 2) ? 32'h304 : 32'h204);
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    // vector table, starting with master 1 as last served
    for (int v = 0; v < 6; v++) begin
      bus.m0_addr = vecs[v].a0;
      bus.m1_addr = vecs[v].a1;
      bus.m0_req = vecs[v].r0;
      bus.m1_req = vecs[v].r1;
      wait_done(40, id, rd, e, rc, rl);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      chk($sformatf("vec%0d id", v), id, vecs[v].exp_id);
      chk($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d err", v), 32'(e), 0);
      repeat (3) @(negedge clk);
    end
    // memory never answers
    mode = 1;
    bus.m0_addr = 32'h700;
    bus.m0_req = 1'b1;
    wait_done(60, id, rd, e, rc, rl);
    bus.m0_req = 1'b0;
    chk("t3 id", id, 0);
    chk("t3 err", 32'(e), 1);
    chk("t3 read cycles", rc, T);
    mode = 0;
    repeat (2) @(negedge clk);
    bus.m1_addr = 32'h800;
    bus.m1_req = 1'b1;
    wait_done(40, id, rd, e, rc, rl);
    bus.m1_req = 1'b0;
    chk("t3 next id", id, 1);
    chk("t3 next rdata", rd, 32'h804);
    chk("t3 next err", 32'(e), 0);
    // ready stuck high after data
    mode = 2;
    bus.m0_addr = 32'h900;
    bus.m0_req = 1'b1;
    wait_done(60, id, rd, e, rc, rl);
    bus.m0_req = 1'b0;
    chk("t4 id", id, 0);
    chk("t4 err", 32'(e), 1);
    chk("t4 release cycles", rl, T);
    mode = 0;
    repeat (6) @(negedge clk);
    // asynchronous reset while in REQ
    bus.m0_addr = 32'hA00;
    bus.m0_req = 1'b1;
    @(negedge clk);
    chk("t5 read before reset", 32'(bus.mem_read), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5 read in reset", 32'(bus.mem_read), 0);
    chk("t5 busy in reset", 32'(bus.busy), 0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done) extra++;
    end
    chk("t5 no done", extra, 0);
    reset = 1'b1;
    wait_done(40, id, rd, e, rc, rl);
    bus.m0_req = 1'b0;
    chk("t5 reserve id", id, 0);
    chk("t5 reserve rdata", rd, 32'hA04);
    chk("t5 reserve err", 32'(e), 0);
    repeat (3) @(negedge clk);
    // master 1 withdraws during REQ
    bus.m1_addr = 32'hB00;
    bus.m1_req = 1'b1;
    @(negedge clk);
    chk("t6 read rise", 32'(bus.mem_read), 1);
    bus.m1_req = 1'b0;
    wait_done(40, id, rd, e, rc, rl);
    chk("t6 id", id, 1);
    chk("t6 rdata", rd, 32'hB04);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_read || bus.busy) extra++;
    end
    chk("t6 no reissue", extra, 0);
    // random traffic against a transaction-level model
    do_reset();
    mfree = 1'b1;
    rel = 1'b0;
    mlast = 1'b1;
    exp_rise = 1'b0;
    exp_addr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (rel) begin
        mfree = 1'b1;
        rel = 1'b0;
      end
      if (exp_rise) begin
        chk("rnd read rise", 32'(bus.mem_read), 1);
        chk("rnd address", bus.mem_address, exp_addr);
        exp_rise = 1'b0;
      end
      if (bus.m0_done || bus.m1_done) begin
        if (q_id.size() == 0) chk("rnd spurious done", 32'(q_id.size()), 1);
        else begin
          id = (bus.m0_done && bus.m1_done) ? 2 : (bus.m1_done ? 1 : 0);
          chk("rnd id", id, q_id[0]);
          chk("rnd rdata", bus.rdata, q_rd[0]);
          chk("rnd err", 32'(bus.err), 0);
          void'(q_id.pop_front());
          void'(q_rd.pop_front());
        end
        if (bus.m0_done) bus.m0_req = 1'b0;
        if (bus.m1_done) bus.m1_req = 1'b0;
        rel = 1'b1;
      end
      if (cyc < 360) begin
        if (!bus.m0_req) begin
          if ($urandom_range(2) == 0) begin
            bus.m0_addr = $urandom & 32'hFFFF_FFFC;
            bus.m0_req = 1'b1;
          end
        end else if ($urandom_range(9) == 0) bus.m0_req = 1'b0;
        if (!bus.m1_req) begin
          if ($urandom_range(2) == 0) begin
            bus.m1_addr = $urandom & 32'hFFFF_FFFC;
            bus.m1_req = 1'b1;
          end
        end else if ($urandom_range(9) == 0) bus.m1_req = 1'b0;
      end else begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      if (mfree && (bus.m0_req || bus.m1_req)) begin
        w = (bus.m0_req && bus.m1_req) ? int'(!mlast) : int'(bus.m1_req);
        exp_addr = w == 1 ? bus.m1_addr : bus.m0_addr;
        q_id.push_back(w);
        q_rd.push_back(exp_addr + 32'd4);
        mlast = w == 1;
        mfree = 1'b0;
        exp_rise = 1'b1;
      end
    end
    chk("rnd drained", 32'(q_id.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_bus_arbiter.md
Name: inst_bus_arbiter

Overview:
Two-master arbiter that sits directly upstream of the instruction-memory bus. Master 0 is instruction fetch; master 1 is debug/aux read.
- Grants the single memory port round-robin.
- Drives the four-phase read handshake (read high -> ready high -> read low -> ready low).
- Returns captured data to the winning master.
- Guards each transaction with a timeout counter.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
SYNC_STAGES, 2, flops on mem_ready (min 1); memory ready is generated off-clock
TIMEOUT_CYCLES, 64, max cycles in any wait state before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 read request; held until m0_done
m0_addr  in  ADDR_W  master 0 address, stable while m0_req
m1_req  in  1  master 1 read request
m1_addr  in  ADDR_W  master 1 address
m0_done  out  1  one-cycle completion pulse to master 0
m1_done  out  1  one-cycle completion pulse to master 1
rdata  out  DATA_W  read data; valid in the done cycle, held until the next capture
err  out  1  qualifies done: 1 = transaction timed out, rdata invalid
busy  out  1  high in any state other than IDLE
mem_read  out  1  read strobe to instruction memory
mem_address  out  ADDR_W  address to instruction memory
mem_ready  in  1  memory data-valid, asynchronous to clk
mem_rdata  in  DATA_W  memory data; valid while mem_ready high

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE.
  - mem_read=0, mem_address=0, rdata=0.
  - m0_done=m1_done=err=busy=0.
  - last_grant=1, so master 0 wins the first tie.
  - Timeout counter=0; sync flops=0.
- Reset mid-transaction: mem_read drops immediately, no done is issued, and masters must re-request.
- rdy_s is mem_ready after SYNC_STAGES flops. Every state decision uses rdy_s only. mem_rdata is captured in the cycle rdy_s is first seen high; memory holds data while ready is high.
- All outputs are registered.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the master other than last_grant.
  - On grant: register mem_address=addr of the winner, mem_read=1, latch grant id, update last_grant, clear counter, go to REQ.
  - Latency: req sampled in cycle N gives mem_read high in cycle N+1.
- REQ:
  - mem_read held high; counter increments each cycle.
  - If rdy_s=1: rdata<=mem_rdata, err<=0, mem_read<=0, go to RELEASE.
  - Else if counter==TIMEOUT_CYCLES-1: err<=1, mem_read<=0, go to RELEASE.
- RELEASE:
  - mem_read=0; counter is cleared on entry.
  - If rdy_s=0, go to DONE.
  - If counter hits TIMEOUT_CYCLES-1 first, set err<=1 and go to DONE.
- DONE:
  - Pulse the granted mN_done for exactly 1 cycle, then go to IDLE.
  - The next grant is possible in the following IDLE cycle, so there is at least one idle cycle between transactions.
- If a master drops req mid-transaction, the transaction still completes and done still pulses. The master ignores it.
- A master re-asserting req in the cycle after its done competes normally. Round-robin guarantees alternation under continuous contention.
- mem_address is stable from the mem_read rise until the DONE exit.
- Counter width is clog2(TIMEOUT_CYCLES). The counter saturates and never wraps.
- busy=1 in REQ, RELEASE and DONE.

Decomposition:
- Package inst_bus_pkg holds:
  - State encoding: IDLE=2'b00, REQ=2'b01, RELEASE=2'b11, DONE=2'b10.
  - Default ADDR_W/DATA_W.
  - Master id constants M0=1'b0, M1=1'b1.
- One sub-module: ready_sync, a SYNC_STAGES-deep flop chain with async active-low reset, instantiated on mem_ready.

Test Plan:
All scenarios use a pseudo memory that returns addr+4 with ready 3 cycles after mem_read rises and drops ready 2 cycles after read falls.
1. Single read: m0_req=1, m0_addr=0x100 -> mem_read rises the next cycle with mem_address=0x100; m0_done pulses once with rdata=0x104, err=0; m1_done stays 0.
2. Contention: both reqs high from reset, m0_addr=0x200, m1_addr=0x300, held for 4 transactions -> grant order m0,m1,m0,m1; rdata 0x204,0x304,0x204,0x304.
3. Timeout: the memory never raises ready, TIMEOUT_CYCLES=8 -> mem_read is high for exactly 8 cycles, then m0_done with err=1. Arbiter then returns to IDLE and serves the next req normally.
4. Stuck ready: ready never falls after data -> after 8 RELEASE cycles, done with err=1.
5. Reset mid-op: reset=0 asserted asynchronously while in REQ -> mem_read=0 and busy=0 before the next clk edge; no done pulse. After release, m0_req is re-served correctly.
6. Request withdrawal: m1 drops req during REQ -> transaction completes, m1_done pulses, and mem_read is not re-asserted without a new req.
